// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter between
// NUM_REQ byte-stream requesters. A grant is held for a whole message (until
// ReqLast, a dropped Req, or MAX_MSG_LEN bytes). Bytes are paced on TxEmpty,
// and a fixed idle gap is inserted after every message.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ARB_IDLE   | no owner; pick the next requester round-robin from r_ptr
// ARB_LOAD   | owner holds grant; wait for TxEmpty then load one byte
// ARB_ACCEPT | byte strobed; wait for the core to take it (TxEmpty low)
// ARB_DRAIN  | core busy shifting the byte; wait for TxEmpty high again
// ARB_GAP    | inter-message idle gap; grant released on exit

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 38399,
    parameter int MAX_MSG_LEN = 256
) (
    input  logic                 Enable,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [8*NUM_REQ-1:0] ReqData,
    input  logic [NUM_REQ-1:0]   ReqLast,
    input  logic                 TxEmpty,
    output logic                 XMitGo,
    output logic [7:0]           TxData,
    output logic [NUM_REQ-1:0]   Ack,
    output logic [NUM_REQ-1:0]   Grant,
    output logic                 Busy
);

    // A gap of 0 still costs one cycle so the FSM always passes through ARB_GAP.
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = $clog2((GAP_CYCLES < 2) ? 2 : GAP_CYCLES);
    localparam int CNT_W   = $clog2(MAX_MSG_LEN + 1);
    localparam int IDX_W   = $clog2(NUM_REQ);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MSG_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_LOAD   = 3'd1,
        ARB_ACCEPT = 3'd2,
        ARB_DRAIN  = 3'd3,
        ARB_GAP    = 3'd4
    } arb_state_t;

    arb_state_t         r_state, w_state_n;
    logic [IDX_W-1:0]   r_ptr, w_ptr_n;
    logic [IDX_W-1:0]   r_gidx, w_gidx_n;
    logic [NUM_REQ-1:0] r_grant, w_grant_n;
    logic               r_xmitgo, w_xmitgo_n;
    logic [7:0]         r_txdata, w_txdata_n;
    logic [NUM_REQ-1:0] r_ack, w_ack_n;
    logic               r_busy, w_busy_n;
    logic               r_last, w_last_n;
    logic [CNT_W-1:0]   r_byte_cnt, w_byte_cnt_n;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_n;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_cand;
    logic               w_req_g;
    logic               w_last_g;
    logic [7:0]         w_data_g;

    // Round-robin search: first requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && Req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Select the current owner's request, data and last flag.
    always_comb begin
        w_req_g  = 1'b0;
        w_last_g = 1'b0;
        w_data_g = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gidx == IDX_W'(i)) begin
                w_req_g  = Req[i];
                w_last_g = ReqLast[i];
                w_data_g = ReqData[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_n    = r_state;
        w_ptr_n      = r_ptr;
        w_gidx_n     = r_gidx;
        w_grant_n    = r_grant;
        w_xmitgo_n   = 1'b0;
        w_txdata_n   = r_txdata;
        w_ack_n      = '0;
        w_last_n     = r_last;
        w_byte_cnt_n = r_byte_cnt;
        w_gap_cnt_n  = r_gap_cnt;

        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_gidx_n     = w_win;
                    w_grant_n    = NUM_REQ'(1) << w_win;
                    w_byte_cnt_n = '0;
                    w_state_n    = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                if (!w_req_g) begin
                    // Owner withdrew mid-message: no further bytes, but the gap still applies.
                    w_gap_cnt_n = '0;
                    w_state_n   = ARB_GAP;
                end else if (TxEmpty) begin
                    w_txdata_n   = w_data_g;
                    w_xmitgo_n   = 1'b1;
                    w_ack_n      = r_grant;
                    w_last_n     = w_last_g | (r_byte_cnt == CNT_LAST);
                    w_byte_cnt_n = r_byte_cnt + 1'b1;
                    w_state_n    = ARB_ACCEPT;
                end
            end
            ARB_ACCEPT: begin
                if (!TxEmpty) begin
                    w_state_n = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (TxEmpty) begin
                    if (r_last) begin
                        w_gap_cnt_n = '0;
                        w_state_n   = ARB_GAP;
                    end else begin
                        w_state_n = ARB_LOAD;
                    end
                end
            end
            ARB_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_grant_n = '0;
                    w_ptr_n   = (r_gidx == IDX_MAX) ? '0 : r_gidx + 1'b1;
                    w_state_n = ARB_IDLE;
                end else begin
                    w_gap_cnt_n = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = ARB_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != ARB_IDLE);
    end

    // State and registered outputs, cleared asynchronously by Reset.
    always_ff @(posedge Enable or posedge Reset) begin
        if (Reset) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_grant    <= '0;
            r_xmitgo   <= 1'b0;
            r_txdata   <= 8'h00;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_last     <= 1'b0;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_ptr      <= w_ptr_n;
            r_gidx     <= w_gidx_n;
            r_grant    <= w_grant_n;
            r_xmitgo   <= w_xmitgo_n;
            r_txdata   <= w_txdata_n;
            r_ack      <= w_ack_n;
            r_busy     <= w_busy_n;
            r_last     <= w_last_n;
            r_byte_cnt <= w_byte_cnt_n;
            r_gap_cnt  <= w_gap_cnt_n;
        end
    end

    assign XMitGo = r_xmitgo;
    assign TxData = r_txdata;
    assign Ack    = r_ack;
    assign Grant  = r_grant;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues and a TX-core model drive
// the DUT; every expected byte is pushed to a scoreboard when its message is
// queued and popped when the DUT strobes XMitGo.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int GAP  = 4;
    localparam int MAXL = 4;

    logic           Enable = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [8*N-1:0] ReqData;
    logic [N-1:0]   ReqLast;
    logic           TxEmpty;
    logic           XMitGo;
    logic [7:0]     TxData;
    logic [N-1:0]   Ack;
    logic [N-1:0]   Grant;
    logic           Busy;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .GAP_CYCLES (GAP),
        .MAX_MSG_LEN(MAXL)
    ) dut (
        .Enable (Enable),
        .Reset  (Reset),
        .Req    (Req),
        .ReqData(ReqData),
        .ReqLast(ReqLast),
        .TxEmpty(TxEmpty),
        .XMitGo (XMitGo),
        .TxData (TxData),
        .Ack    (Ack),
        .Grant  (Grant),
        .Busy   (Busy)
    );

    always #5 Enable = ~Enable;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  rq [N][$];   // {last, byte} per requester
    logic [10:0] sb [$];      // {requester, byte} in expected transmit order
    int          tx_cnt      = 0;
    int          xmit_total  = 0;
    int          ack_total [N];
    bit          saw_xmit    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) begin
                Req[i]           = 1'b1;
                ReqData[8*i +: 8] = rq[i][0][7:0];
                ReqLast[i]       = rq[i][0][8];
            end else begin
                Req[i]           = 1'b0;
                ReqData[8*i +: 8] = 8'h00;
                ReqLast[i]       = 1'b0;
            end
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic last);
        rq[r].push_back({last, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        logic [2:0] ri;
        ri = 3'(r);
        sb.push_back({ri, d});
    endtask

    // One clock: sample at the falling edge, score, then update the models and inputs.
    task automatic step();
        logic [10:0] e;
        @(negedge Enable);
        saw_xmit = 1'b0;
        check("ack_with_xmit", 32'(Ack != '0), 32'(XMitGo));
        check("ack_onehot0", 32'($onehot0(Ack)), 32'd1);
        if (XMitGo === 1'b1) begin
            saw_xmit = 1'b1;
            xmit_total++;
            check("xmit_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("txdata", 32'(TxData), 32'(e[7:0]));
                check("grant", 32'(Grant), 32'd1 << e[10:8]);
                check("ack", 32'(Ack), 32'd1 << e[10:8]);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (Ack[i] === 1'b1) begin
                ack_total[i]++;
                if (rq[i].size() != 0) void'(rq[i].pop_front());
            end
        end
        if (XMitGo === 1'b1) begin
            tx_cnt  = 10;
            TxEmpty = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) TxEmpty = 1'b1;
        end
        drive_req();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(Busy === 1'b0 && all_empty()) && n < max_cycles);
        check({tag, "_idle"}, 32'(Busy === 1'b0 && all_empty()), 32'd1);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Waits for the last scoreboard byte and the end of its drain, then counts Busy cycles.
    task automatic measure_tail(output int gap_len, output logic [N-1:0] gap_grant);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin step(); n++; end
        n = 0;
        while (TxEmpty !== 1'b1 && n < 50) begin step(); n++; end
        gap_len   = 0;
        gap_grant = '0;
        n = 0;
        do begin
            step();
            n++;
            if (Busy === 1'b1) begin
                gap_len++;
                gap_grant = Grant;
            end
        end while (Busy === 1'b1 && n < 50);
    endtask

    initial begin
        int          lat;
        int          glen;
        int          xm0;
        int          ak0;
        logic [N-1:0] gg;

        for (int i = 0; i < N; i++) ack_total[i] = 0;
        Reset   = 1'b1;
        TxEmpty = 1'b1;
        Req     = '0;
        ReqData = '0;
        ReqLast = '0;

        // Reset held with random requests: everything stays quiet.
        for (int c = 0; c < 12; c++) begin
            @(negedge Enable);
            check("rst_xmitgo", 32'(XMitGo), 32'd0);
            check("rst_grant", 32'(Grant), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
            check("rst_txdata", 32'(TxData), 32'd0);
            check("rst_ack", 32'(Ack), 32'd0);
            Req     = N'($urandom);
            ReqData = {$urandom, $urandom};
            ReqLast = N'($urandom);
        end
        @(negedge Enable);
        Req     = '0;
        ReqData = '0;
        ReqLast = '0;
        Reset   = 1'b0;

        // Three-byte message on requester 0: latency, content, gap length.
        xm0 = xmit_total;
        ak0 = ack_total[0];
        add_byte(0, 8'h41, 1'b0); expect_byte(0, 8'h41);
        add_byte(0, 8'h42, 1'b0); expect_byte(0, 8'h42);
        add_byte(0, 8'h43, 1'b1); expect_byte(0, 8'h43);
        drive_req();
        lat = 0;
        do begin step(); lat++; end while (!saw_xmit && lat < 20);
        check("first_xmit_latency", 32'(lat), 32'd2);
        measure_tail(glen, gg);
        check("msg3_gap_len", 32'(glen), 32'(GAP));
        check("msg3_gap_grant", 32'(gg), 32'b0001);
        check("msg3_grant_after", 32'(Grant), 32'd0);
        check("msg3_xmit_count", 32'(xmit_total - xm0), 32'd3);
        check("msg3_ack_count", 32'(ack_total[0] - ak0), 32'd3);

        // Requester 2 withdraws after two bytes without Last: aborted, gap still applies.
        xm0 = xmit_total;
        add_byte(2, 8'h21, 1'b0); expect_byte(2, 8'h21);
        add_byte(2, 8'h22, 1'b0); expect_byte(2, 8'h22);
        drive_req();
        measure_tail(glen, gg);
        check("abort_gap_len", 32'(glen), 32'(GAP + 1));
        check("abort_gap_grant", 32'(gg), 32'b0100);
        check("abort_grant_after", 32'(Grant), 32'd0);
        for (int c = 0; c < 5; c++) step();
        check("abort_xmit_count", 32'(xmit_total - xm0), 32'd2);

        // Reset during ARB_DRAIN; afterwards arbitration restarts from pointer 0.
        add_byte(1, 8'h31, 1'b0); expect_byte(1, 8'h31);
        add_byte(1, 8'h32, 1'b0); expect_byte(1, 8'h32);
        add_byte(1, 8'h33, 1'b1); expect_byte(1, 8'h33);
        drive_req();
        lat = 0;
        do begin step(); lat++; end while (!saw_xmit && lat < 20);
        step();
        step();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        check("pre_rst_grant", 32'(Grant), 32'b0010);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_xmitgo", 32'(XMitGo), 32'd0);
        check("async_rst_grant", 32'(Grant), 32'd0);
        check("async_rst_busy", 32'(Busy), 32'd0);
        check("async_rst_txdata", 32'(TxData), 32'd0);
        check("async_rst_ack", 32'(Ack), 32'd0);
        add_byte(3, 8'h41, 1'b1); expect_byte(3, 8'h41);
        drive_req();
        step();
        step();
        #1 Reset = 1'b0;
        run_until_idle("post_rst", 400);

        // Requester 1 never sends Last: cut off after MAXL bytes, requester 2 served next.
        for (int b = 0; b < 6; b++) add_byte(1, 8'(8'h50 + b), 1'b0);
        add_byte(2, 8'h60, 1'b1);
        for (int b = 0; b < 4; b++) expect_byte(1, 8'(8'h50 + b));
        expect_byte(2, 8'h60);
        expect_byte(1, 8'h54);
        expect_byte(1, 8'h55);
        drive_req();
        run_until_idle("maxlen", 600);

        // Fresh reset, then all four requesters with 1-byte messages: 0,1,2,3,0.
        #1 Reset = 1'b1;
        step();
        Reset = 1'b0;
        add_byte(0, 8'h70, 1'b1); expect_byte(0, 8'h70);
        add_byte(1, 8'h71, 1'b1); expect_byte(1, 8'h71);
        add_byte(2, 8'h72, 1'b1); expect_byte(2, 8'h72);
        add_byte(3, 8'h73, 1'b1); expect_byte(3, 8'h73);
        add_byte(0, 8'h74, 1'b1); expect_byte(0, 8'h74);
        drive_req();
        run_until_idle("rr_wrap", 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
